axis_packet_framer: RTL
=======================

AXIS_PACKET_FRAMER -- requirements
Module: axis_packet_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width in bits; SHALL be a multiple of 8.
REQ-002 Parameter PKT_LEN, default 8, maximum payload words per packet before a forced packet close.
REQ-003 Port s01_axis_aclk, input, 1 bit: sole clock; all logic SHALL be rising-edge.
REQ-004 Port s01_axis_aresetn, input, 1 bit: asynchronous, active-low reset for the whole block.
REQ-005 Port s01_axis_tdata, input, DATA_WIDTH bits: payload word from the memory_controller master port.
REQ-006 Port s01_axis_tstrb, input, DATA_WIDTH/8 bits: byte qualifiers.
REQ-007 Port s01_axis_tvalid, input, 1 bit: input word valid.
REQ-008 Port s01_axis_tlast, input, 1 bit: last payload word of the packet.
REQ-009 Port s01_axis_tready, output, 1 bit: block accepts the input word.
REQ-010 Port m01_axis_tready, input, 1 bit: downstream accepts the output word.
REQ-011 Port m01_axis_tdata, output, DATA_WIDTH bits: payload or checksum word.
REQ-012 Port m01_axis_tstrb, output, DATA_WIDTH/8 bits: byte qualifiers.
REQ-013 Port m01_axis_tvalid, output, 1 bit: output word valid.
REQ-014 Port m01_axis_tlast, output, 1 bit: asserted only on the checksum word.
REQ-015 Port pkt_count, output, 16 bits: number of checksum words accepted downstream.

Function
REQ-016 An input transfer SHALL occur on a clock edge with s01_axis_tvalid and s01_axis_tready both high; an output transfer SHALL occur with m01_axis_tvalid and m01_axis_tready both high.
REQ-017 FSM states: IDLE (no word of the current packet accepted), PAYLOAD (at least one word accepted), CHECKSUM (checksum word pending).
REQ-018 Transitions: IDLE->PAYLOAD on the first input transfer; IDLE/PAYLOAD->CHECKSUM on an input transfer with tlast=1 or with word count = PKT_LEN; CHECKSUM->IDLE on the output transfer of the checksum word.
REQ-019 s01_axis_tready SHALL equal (state != CHECKSUM) AND (m01_axis_tvalid = 0 OR m01_axis_tready = 1).
REQ-020 Each accepted payload word SHALL appear on m01_axis_tdata/tstrb with m01_axis_tvalid high one cycle after acceptance, with m01_axis_tlast = 0 and tstrb passed through unchanged.
REQ-021 Once m01_axis_tvalid is high, tdata, tstrb and tlast SHALL hold stable until the output transfer.
REQ-022 The checksum SHALL be the modulo-2^DATA_WIDTH sum of the payload words, with bytes whose tstrb bit is 0 counted as zero; overflow SHALL wrap silently.
REQ-023 The checksum word SHALL follow the last payload word on the next output slot, with tstrb all ones and tlast = 1.
REQ-024 The sum and word counter SHALL clear when the checksum word is loaded into the output register.
REQ-025 A forced close (PKT_LEN words, no tlast) SHALL be identical to a tlast close; the next input word SHALL start a new packet.
REQ-026 pkt_count SHALL increment on each checksum output transfer and wrap from 0xFFFF to 0.
REQ-027 A zero-word packet SHALL never be produced.

Reset
REQ-028 While s01_axis_aresetn = 0: state = IDLE, sum = 0, word count = 0, pkt_count = 0, m01_axis_tvalid = 0, m01_axis_tlast = 0, m01_axis_tdata = 0, m01_axis_tstrb = 0, s01_axis_tready = 0.
REQ-029 A reset asserted mid-packet SHALL discard the partial packet with no checksum emitted; after release, s01_axis_tready SHALL go high on the first clock edge.

Structure
REQ-030 A shared package axis_pkg SHALL hold the FSM state encodings and the default DATA_WIDTH/PKT_LEN constants.
REQ-031 The output register with hold-until-ready behaviour SHALL be the sub-module axis_out_reg, instantiated once.

Verification
REQ-032 Input 0x55, 0x22, 0x24 (tlast on 0x24) with m01_axis_tready=1 -> outputs 0x55, 0x22, 0x24 (tlast=0), then 0x9B (tlast=1, tstrb=4'hF); pkt_count=1.
REQ-033 Same stimulus with m01_axis_tready=0 for 5 cycles mid-packet -> m01_axis_tvalid held high, tdata stable, s01_axis_tready low; stream completes unchanged when ready returns.
REQ-034 Input words 1..8 with no tlast (PKT_LEN=8) -> checksum 0x24 with tlast after word 8; a following word 0x10 with tlast -> 0x10, then checksum 0x10.
REQ-035 Input 0xAABBCCDD with tstrb=4'b0011 and tlast -> payload 0xAABBCCDD with tstrb 4'b0011, then checksum 0x0000CCDD.
REQ-036 Input 0xFFFFFFFF, 0x00000002 (tlast) -> checksum 0x00000001.
REQ-037 Reset asserted after 2 words of a packet -> all outputs at reset values, no checksum emitted; the next packet 0x7 (tlast) -> 0x7, then checksum 0x7, pkt_count=1.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared constants and FSM encoding for the AXI-Stream packet framer.
package axis_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned DEFAULT_PKT_LEN    = 8;
   localparam int unsigned PKT_COUNT_W        = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PAYLOAD  = 2'd1,
      ST_CHECKSUM = 2'd2
   } state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Output skid-free register: loads a word when the slot is free and holds it
// stable until the downstream handshake completes.
module axis_out_reg #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [DATA_WIDTH-1:0]   load_data,
   input  logic [DATA_WIDTH/8-1:0] load_strb,
   input  logic                    load_last,
   input  logic                    tready,
   output logic                    tvalid,
   output logic [DATA_WIDTH-1:0]   tdata,
   output logic [DATA_WIDTH/8-1:0] tstrb,
   output logic                    tlast
);

   // Load wins over drain: the parent only loads when the slot frees this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tvalid <= 1'b0;
         tdata  <= '0;
         tstrb  <= '0;
         tlast  <= 1'b0;
      end else if (load) begin
         tvalid <= 1'b1;
         tdata  <= load_data;
         tstrb  <= load_strb;
         tlast  <= load_last;
      end else if (tvalid && tready) begin
         tvalid <= 1'b0;
         tlast  <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_packet_framer.sv
// Forwards payload words and appends a strobe-masked additive checksum word
// after each packet (closed by tlast or by reaching PKT_LEN words).
module axis_packet_framer
   import axis_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned PKT_LEN    = DEFAULT_PKT_LEN
) (
   input  logic                    s01_axis_aclk,
   input  logic                    s01_axis_aresetn,
   input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
   input  logic                    s01_axis_tvalid,
   input  logic                    s01_axis_tlast,
   output logic                    s01_axis_tready,
   input  logic                    m01_axis_tready,
   output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
   output logic                    m01_axis_tvalid,
   output logic                    m01_axis_tlast,
   output logic [PKT_COUNT_W-1:0]  pkt_count
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned CNT_W  = $clog2(PKT_LEN + 1);

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   sum_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_inc;
   logic                    rst_done_q;
   logic [PKT_COUNT_W-1:0]  pkt_count_q;

   logic                    slot_free;
   logic                    in_ready;
   logic                    in_xfer;
   logic                    out_xfer;
   logic                    pkt_close;
   logic                    cks_load;
   logic                    out_load;
   logic [DATA_WIDTH-1:0]   out_data;
   logic [STRB_W-1:0]       out_strb;
   logic                    out_last;
   logic [DATA_WIDTH-1:0]   masked;

   assign slot_free = !m01_axis_tvalid || m01_axis_tready;
   assign in_xfer   = s01_axis_tvalid && in_ready;
   assign out_xfer  = m01_axis_tvalid && m01_axis_tready;
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign pkt_close = s01_axis_tlast || (cnt_inc == CNT_W'(PKT_LEN));

   // Bytes with a cleared strobe contribute zero to the checksum.
   always_comb begin
      masked = '0;
      for (int b = 0; b < STRB_W; b++) begin
         masked[b*8 +: 8] = s01_axis_tstrb[b] ? s01_axis_tdata[b*8 +: 8] : 8'h00;
      end
   end

   always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
      if (!s01_axis_aresetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_xfer) begin
               state_d = pkt_close ? ST_CHECKSUM : ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (in_xfer && pkt_close) begin
               state_d = ST_CHECKSUM;
            end
         end
         ST_CHECKSUM: begin
            if (out_xfer && m01_axis_tlast) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Checksum is loaded once the last payload word leaves; tlast marks it as already loaded.
   always_comb begin
      in_ready = 1'b0;
      cks_load = 1'b0;
      out_load = 1'b0;
      out_data = s01_axis_tdata;
      out_strb = s01_axis_tstrb;
      out_last = 1'b0;
      if (state_q == ST_CHECKSUM) begin
         cks_load = !m01_axis_tvalid || (m01_axis_tready && !m01_axis_tlast);
         out_load = cks_load;
         out_data = sum_q;
         out_strb = '1;
         out_last = 1'b1;
      end else begin
         in_ready = rst_done_q && slot_free;
         out_load = s01_axis_tvalid && rst_done_q && slot_free;
      end
   end

   assign s01_axis_tready = in_ready;

   always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
      if (!s01_axis_aresetn) begin
         sum_q <= '0;
         cnt_q <= '0;
      end else if (cks_load) begin
         sum_q <= '0;
         cnt_q <= '0;
      end else if (in_xfer) begin
         sum_q <= sum_q + masked;
         cnt_q <= cnt_inc;
      end
   end

   // Holds input ready low through reset and releases it on the first edge after.
   always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
      if (!s01_axis_aresetn) begin
         rst_done_q <= 1'b0;
      end else begin
         rst_done_q <= 1'b1;
      end
   end

   always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
      if (!s01_axis_aresetn) begin
         pkt_count_q <= '0;
      end else if (out_xfer && m01_axis_tlast) begin
         pkt_count_q <= pkt_count_q + PKT_COUNT_W'(1);
      end
   end

   assign pkt_count = pkt_count_q;

   axis_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_reg (
      .clk       (s01_axis_aclk),
      .rst_n     (s01_axis_aresetn),
      .load      (out_load),
      .load_data (out_data),
      .load_strb (out_strb),
      .load_last (out_last),
      .tready    (m01_axis_tready),
      .tvalid    (m01_axis_tvalid),
      .tdata     (m01_axis_tdata),
      .tstrb     (m01_axis_tstrb),
      .tlast     (m01_axis_tlast)
   );

endmodule
